onion_breathe_sequencer: RTL
============================

Name: onion_breathe_sequencer

Overview:
- Wishbone-slave controller that sequences the three breathe engines (R/G/B) through a programmable step table.
- Each step selects which channels breathe and how long the step lasts.
- Drives one 32-bit config word per breathe engine, in the layout {EN[31], 7'b0, CLK_CYCLES_PER_STEP[23:0]}.
- Sits between the AHB-to-FPGA Wishbone bridge and the breathe engine instances. Firmware loads a light pattern once; the block then runs it without CPU involvement.

Parameters:
- NUM_STEPS, 8, number of step-table entries (power of 2, max 16).
- TICK_DIV, 16'd12000, WBs_CLK_i cycles per hold tick (1 ms at 12 MHz).
- DEFAULT_REG_VALUE, 32'hDEF_FAB_AC, read value for unmapped addresses.
- DEFAULT_PERIOD, 24'hAAAA, reset value of each channel period.

Ports:
- WBs_CLK_i input 1 system/Wishbone clock.
- WBs_RST_i input 1 asynchronous active-high reset.
- WBs_ADR_i input 17 byte address; bits [9:2] decoded.
- WBs_CYC_i input 1 cycle select.
- WBs_STB_i input 1 strobe.
- WBs_WE_i input 1 write enable.
- WBs_BYTE_STB_i input 4 byte lanes.
- WBs_DAT_i input 32 write data.
- WBs_DAT_o output 32 read data (combinational).
- WBs_ACK_o output 1 acknowledge.
- BREATHE_0_CFG_o output 32 config word for breathe engine 0.
- BREATHE_1_CFG_o output 32 config word for breathe engine 1.
- BREATHE_2_CFG_o output 32 config word for breathe engine 2.
- SEQ_DONE_o output 1 one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Interface: reset WBs_RST_i, asynchronous, active-high; clock WBs_CLK_i.
- Wishbone:
  - WBs_ACK_o registered: next = CYC & STB & ~ACK.
  - Single-cycle ack on every access, including unmapped addresses.
  - Writes happen when CYC & STB & WE & ~ACK, with per-byte strobes.
- Register map:
  - 0x000 CTRL: [0] START (W1 pulse, reads 0); [1] STOP (W1 pulse, reads 0); [2] LOOP; [6:3] LAST_STEP; [10:8] MANUAL_EN.
  - 0x004 STATUS (RO): [0] BUSY; [4:1] CUR_STEP; [15:8] LOOP_CNT.
  - 0x010, 0x014, 0x018 PERIOD_0..2: [23:0] period, reset DEFAULT_PERIOD.
  - 0x040 + 4*i STEP_i: [2:0] EN_MASK; [31:8] HOLD (ticks); [7:3] reserved, read 0.
- Reset values:
  - All CTRL bits 0; BUSY 0; CUR_STEP 0; LOOP_CNT 0; SEQ_DONE_o 0.
  - Step table all 0.
  - BREATHE_x_CFG_o = {1'b0, 7'b0, 24'hAAAA}.
- FSM states: IDLE, APPLY, HOLD.
  - IDLE:
    - Channel enable = MANUAL_EN[x].
    - START -> APPLY, step = 0, LOOP_CNT = 0, prescaler cleared.
  - APPLY (1 cycle):
    - Latch EN_MASK of the current step into the active mask.
    - Load hold_cnt = HOLD.
    - Go to HOLD.
  - HOLD:
    - Prescaler counts 0..TICK_DIV-1; on wrap, hold_cnt decrements.
    - When hold_cnt == 0 the step ends. Check for zero before decrementing, so HOLD=0 lasts exactly 1 cycle in HOLD.
    - If step == LAST_STEP and LOOP=1: step 0, LOOP_CNT + 1 (saturates at 255), go to APPLY.
    - If step == LAST_STEP and LOOP=0: go to IDLE, pulse SEQ_DONE_o for 1 cycle.
    - Otherwise: step + 1, go to APPLY.
- Outputs: BREATHE_x_CFG_o = {en_x, 7'b0, PERIOD_x}, registered.
  - en_x = active mask bit when BUSY, MANUAL_EN bit when IDLE.
  - A PERIOD write is visible on the outputs 1 cycle after the write cycle.
- BUSY = state != IDLE. CUR_STEP reflects the step register.
- Boundary rules:
  - START while BUSY: ignored.
  - STOP in any state: IDLE on the next cycle, no SEQ_DONE_o pulse. Enables revert to MANUAL_EN.
  - START and STOP in the same write: STOP wins.
  - LAST_STEP >= NUM_STEPS: clamped to NUM_STEPS-1.
  - Step-table or PERIOD writes while BUSY are allowed. A table entry takes effect at that step's next APPLY.
  - Reset mid-sequence: immediate return to reset values, no pulse.

Decomposition:
- Shared package holds:
  - Register offsets (CTRL, STATUS, PERIOD_x, STEP_BASE).
  - CTRL/STEP bit-field positions.
  - FSM state encoding.
  - DEFAULT_REG_VALUE.
- One natural sub-module: onion_tick_prescaler (counter with clear and a tick pulse output).
- The register file and FSM stay in the top block.

Test Plan (TICK_DIV=4 in sim):
- Reset, then read all registers -> CTRL=0; STATUS=0; PERIOD_x=0x0000AAAA; unmapped 0x3FC reads 0xDEFFABAC; CFG_o EN bits 0.
- STEP0={HOLD=3, EN=3'b001}, STEP1={HOLD=2, EN=3'b110}, LAST_STEP=1, START -> ch0 enabled for 1+1+12 cycles after APPLY; then ch1/ch2 enabled for 8 ticks of cycles; SEQ_DONE_o pulses once; BUSY=0.
- Same program with LOOP=1, run 3 full passes -> LOOP_CNT=3. STOP mid-step 1 -> BUSY=0 next cycle, no SEQ_DONE_o, EN bits = MANUAL_EN=3'b010.
- Write CTRL with START|STOP=0x3 from IDLE -> BUSY stays 0. START while BUSY -> CUR_STEP not reset.
- STEP0 HOLD=0, LAST_STEP=0 -> exactly APPLY + 1 HOLD cycle, then SEQ_DONE_o. LAST_STEP=15 with NUM_STEPS=8 -> sequence ends after step 7.
- Write PERIOD_1=0x001234 using byte strobe 4'b0001 only -> PERIOD_1=0x00AA34; CFG_1 updates 1 cycle later. Assert WBs_RST_i mid-HOLD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/onion_breathe_sequencer_pkg.sv
// Shared definitions for the breathe sequencer: register word offsets, field
// positions, FSM encoding and the byte-lane merge helper.
package onion_breathe_sequencer_pkg;

  // Word offsets, i.e. WBs_ADR_i[9:2]
  localparam logic [7:0] ADR_CTRL      = 8'h00;
  localparam logic [7:0] ADR_STATUS    = 8'h01;
  localparam logic [7:0] ADR_PERIOD_0  = 8'h04;
  localparam logic [7:0] ADR_PERIOD_1  = 8'h05;
  localparam logic [7:0] ADR_PERIOD_2  = 8'h06;
  localparam logic [7:0] ADR_STEP_BASE = 8'h10;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_STOP_BIT   = 1;
  localparam int CTRL_LOOP_BIT   = 2;
  localparam int CTRL_LAST_LSB   = 3;
  localparam int CTRL_MANUAL_LSB = 8;

  localparam int STEP_EN_LSB   = 0;
  localparam int STEP_HOLD_LSB = 8;

  localparam logic [31:0] DFLT_REG_VALUE = 32'hDEF_FAB_AC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/onion_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV clocks;
// clear holds it at zero so the first tick is a full period away.
module onion_tick_prescaler #(
  parameter logic [15:0] TICK_DIV = 16'd12000
) (
  input  logic WBs_CLK_i,
  input  logic WBs_RST_i,
  input  logic clear,
  output logic tick
);

  logic [15:0] count_r;
  logic        wrap;

  assign wrap = (count_r == (TICK_DIV - 16'd1));
  assign tick = ~clear & wrap;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      count_r <= 16'd0;
    end else if (clear || wrap) begin
      count_r <= 16'd0;
    end else begin
      count_r <= count_r + 16'd1;
    end
  end

endmodule

// File: rtl/onion_breathe_sequencer.sv
// Wishbone-programmable step sequencer driving the config words of the three
// breathe engines; runs a loaded pattern without CPU involvement.
module onion_breathe_sequencer #(
  parameter int          NUM_STEPS         = 8,
  parameter logic [15:0] TICK_DIV          = 16'd12000,
  parameter logic [31:0] DEFAULT_REG_VALUE = onion_breathe_sequencer_pkg::DFLT_REG_VALUE,
  parameter logic [23:0] DEFAULT_PERIOD    = 24'hAAAA
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic [16:0] WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic        WBs_STB_i,
  input  logic        WBs_WE_i,
  input  logic [3:0]  WBs_BYTE_STB_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  output logic [31:0] BREATHE_0_CFG_o,
  output logic [31:0] BREATHE_1_CFG_o,
  output logic [31:0] BREATHE_2_CFG_o,
  output logic        SEQ_DONE_o
);
  import onion_breathe_sequencer_pkg::*;

  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic              ack_r;
  logic [7:0]        adr_word;
  logic              wr_en, ctrl_wr, start_req, stop_req, is_step, tick;
  logic [STEP_W-1:0] tbl_idx, step_idx;
  logic [31:0]       step_merged, rd_data;
  logic              unused_bits;

  logic              loop_r, loop_n;
  logic [3:0]        last_step_r, last_step_n, last_eff;
  logic [2:0]        manual_en_r, manual_en_n;
  logic [23:0]       period_r [3];
  logic [23:0]       period_n [3];
  logic [2:0]        step_en   [NUM_STEPS];
  logic [23:0]       step_hold [NUM_STEPS];

  seq_state_e        state, state_n;
  logic [3:0]        step_r, step_n;
  logic [2:0]        mask_r, mask_n, en_n;
  logic [23:0]       hold_r, hold_n;
  logic [7:0]        loop_cnt_r, loop_cnt_n;
  logic              done_n, seq_done_r;
  logic [31:0]       cfg_r [3];

  assign adr_word    = WBs_ADR_i[9:2];
  assign wr_en       = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~ack_r;
  assign ctrl_wr     = wr_en & (adr_word == ADR_CTRL) & WBs_BYTE_STB_i[0];
  assign stop_req    = ctrl_wr & WBs_DAT_i[CTRL_STOP_BIT];
  assign start_req   = ctrl_wr & WBs_DAT_i[CTRL_START_BIT] & ~WBs_DAT_i[CTRL_STOP_BIT];
  assign is_step     = (adr_word >= ADR_STEP_BASE) &&
                       (adr_word < (ADR_STEP_BASE + 8'(NUM_STEPS)));
  assign tbl_idx     = STEP_W'(adr_word - ADR_STEP_BASE);
  assign step_idx    = step_r[STEP_W-1:0];
  assign last_eff    = ({1'b0, last_step_r} >= 5'(NUM_STEPS)) ? 4'(NUM_STEPS - 1) : last_step_r;
  assign step_merged = byte_merge({step_hold[tbl_idx], 5'b0, step_en[tbl_idx]},
                                  WBs_DAT_i, WBs_BYTE_STB_i);
  assign unused_bits = ^{WBs_ADR_i[16:10], WBs_ADR_i[1:0], step_merged[7:3]};

  onion_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .WBs_CLK_i (WBs_CLK_i),
    .WBs_RST_i (WBs_RST_i),
    .clear     (state != ST_HOLD),
    .tick      (tick)
  );

  // Next values of CTRL and PERIOD are shared with the output register so a
  // write shows up on the config words right after its own write edge.
  always_comb begin
    loop_n      = loop_r;
    last_step_n = last_step_r;
    manual_en_n = manual_en_r;
    for (int i = 0; i < 3; i++) period_n[i] = period_r[i];
    if (ctrl_wr) begin
      loop_n      = WBs_DAT_i[CTRL_LOOP_BIT];
      last_step_n = WBs_DAT_i[CTRL_LAST_LSB +: 4];
    end
    if (wr_en && (adr_word == ADR_CTRL) && WBs_BYTE_STB_i[1])
      manual_en_n = WBs_DAT_i[CTRL_MANUAL_LSB +: 3];
    for (int i = 0; i < 3; i++) begin
      if (wr_en && (adr_word == (ADR_PERIOD_0 + 8'(i))))
        period_n[i] = 24'(byte_merge({8'h00, period_r[i]}, WBs_DAT_i, WBs_BYTE_STB_i));
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ack_r       <= 1'b0;
      loop_r      <= 1'b0;
      last_step_r <= 4'd0;
      manual_en_r <= 3'd0;
      for (int i = 0; i < 3; i++) period_r[i] <= DEFAULT_PERIOD;
      for (int s = 0; s < NUM_STEPS; s++) begin
        step_en[s]   <= 3'd0;
        step_hold[s] <= 24'd0;
      end
    end else begin
      ack_r       <= WBs_CYC_i & WBs_STB_i & ~ack_r;
      loop_r      <= loop_n;
      last_step_r <= last_step_n;
      manual_en_r <= manual_en_n;
      for (int i = 0; i < 3; i++) period_r[i] <= period_n[i];
      if (wr_en && is_step) begin
        step_en[tbl_idx]   <= step_merged[STEP_EN_LSB +: 3];
        step_hold[tbl_idx] <= step_merged[STEP_HOLD_LSB +: 24];
      end
    end
  end

  // Hold count is tested before it is decremented, so HOLD=0 spends one cycle in HOLD.
  always_comb begin
    state_n    = state;
    step_n     = step_r;
    mask_n     = mask_r;
    hold_n     = hold_r;
    loop_cnt_n = loop_cnt_r;
    done_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_n    = ST_APPLY;
          step_n     = 4'd0;
          loop_cnt_n = 8'd0;
          mask_n     = 3'd0;
        end
      end
      ST_APPLY: begin
        mask_n  = step_en[step_idx];
        hold_n  = step_hold[step_idx];
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_r == 24'd0) begin
          if (step_r == last_eff) begin
            if (loop_r) begin
              step_n     = 4'd0;
              loop_cnt_n = (loop_cnt_r == 8'hFF) ? 8'hFF : loop_cnt_r + 8'd1;
              state_n    = ST_APPLY;
            end else begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end else begin
            step_n  = step_r + 4'd1;
            state_n = ST_APPLY;
          end
        end else if (tick) begin
          hold_n = hold_r - 24'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (stop_req) begin
      state_n = ST_IDLE;
      done_n  = 1'b0;
    end
  end

  assign en_n = (state_n == ST_IDLE) ? manual_en_n : mask_n;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state      <= ST_IDLE;
      step_r     <= 4'd0;
      mask_r     <= 3'd0;
      hold_r     <= 24'd0;
      loop_cnt_r <= 8'd0;
      seq_done_r <= 1'b0;
      for (int i = 0; i < 3; i++) cfg_r[i] <= {1'b0, 7'b0, DEFAULT_PERIOD};
    end else begin
      state      <= state_n;
      step_r     <= step_n;
      mask_r     <= mask_n;
      hold_r     <= hold_n;
      loop_cnt_r <= loop_cnt_n;
      seq_done_r <= done_n;
      for (int i = 0; i < 3; i++) cfg_r[i] <= {en_n[i], 7'b0, period_n[i]};
    end
  end

  always_comb begin
    rd_data = DEFAULT_REG_VALUE;
    if (adr_word == ADR_CTRL)
      rd_data = {21'h0, manual_en_r, 1'b0, last_step_r, loop_r, 2'b00};
    else if (adr_word == ADR_STATUS)
      rd_data = {16'h0, loop_cnt_r, 3'b0, step_r, state != ST_IDLE};
    else if (adr_word == ADR_PERIOD_0)
      rd_data = {8'h00, period_r[0]};
    else if (adr_word == ADR_PERIOD_1)
      rd_data = {8'h00, period_r[1]};
    else if (adr_word == ADR_PERIOD_2)
      rd_data = {8'h00, period_r[2]};
    else if (is_step)
      rd_data = {step_hold[tbl_idx], 5'b0, step_en[tbl_idx]};
  end

  assign WBs_DAT_o       = rd_data;
  assign WBs_ACK_o       = ack_r;
  assign BREATHE_0_CFG_o = cfg_r[0];
  assign BREATHE_1_CFG_o = cfg_r[1];
  assign BREATHE_2_CFG_o = cfg_r[2];
  assign SEQ_DONE_o      = seq_done_r;

endmodule
